// File: rtl/ikaopll_pkg.sv
// Shared constants and sample helpers for the IKAOPLL DAC mixer.
// The helpers work on 32-bit ints; callers size the result to their own width.
package ikaopll_pkg;

  localparam int SLOTS_DEF      = 18;
  localparam int IN_W_DEF       = 9;
  localparam int OUT_W_DEF      = 13;
  localparam int MO_SHIFT_DEF   = 0;
  localparam int RO_SHIFT_DEF   = 1;
  localparam int DLY_DEF        = 3;
  localparam int FIFO_DEPTH_DEF = 2;

  // A set sign bit with magnitude m decodes to -(m+1), i.e. the word {1,~m}.
  function automatic int sm_to_int(input int raw, input int in_w);
    int mag;
    mag = raw & ((1 << (in_w - 1)) - 1);
    return raw[in_w-1] ? -(mag + 1) : mag;
  endfunction

  function automatic int sat_int(input int v, input int out_w);
    int hi;
    int lo;
    hi = (1 << (out_w - 1)) - 1;
    lo = -(1 << (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ikaopll_dac_mixer_fifo.sv
// Small result buffer between the frame accumulator and the DAC consumer.
// A push into a full buffer succeeds only when the head is popped on the same edge.
module ikaopll_dac_mixer_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
)(
  input  logic         emuclk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge emuclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      if (do_push & ~do_pop)      count <= count + 1'b1;
      else if (do_pop & ~do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge emuclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ikaopll_dac_mixer.sv
// Per-frame melody/rhythm summer: accumulates weighted samples between delayed
// frame markers and queues saturated MO/RO/MIX results for the DAC side.
module ikaopll_dac_mixer
  import ikaopll_pkg::*;
#(
  parameter int SLOTS      = SLOTS_DEF,
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int MO_SHIFT   = MO_SHIFT_DEF,
  parameter int RO_SHIFT   = RO_SHIFT_DEF,
  parameter int DLY        = DLY_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)(
  input  logic                    i_EMUCLK,
  input  logic                    i_RST,
  input  logic                    i_phi1_NCEN_n,
  input  logic                    i_CYCLE_00,
  input  logic                    i_SAMPLE_VALID,
  input  logic                    i_GROUP,
  input  logic [IN_W-1:0]         i_SAMPLE,
  output logic                    o_VALID,
  input  logic                    i_READY,
  output logic signed [OUT_W-1:0] o_MO_DATA,
  output logic signed [OUT_W-1:0] o_RO_DATA,
  output logic signed [OUT_W-1:0] o_MIX_DATA,
  output logic                    o_OVF
);

  localparam int MAX_SH = (MO_SHIFT > RO_SHIFT) ? MO_SHIFT : RO_SHIFT;
  localparam int ACC_W  = IN_W + $clog2(SLOTS) + MAX_SH + 1;
  localparam int ENT_W  = 3 * OUT_W;

  logic [DLY-1:0]           dly_sr;
  logic signed [ACC_W-1:0]  mo_acc;
  logic signed [ACC_W-1:0]  ro_acc;
  logic signed [ACC_W-1:0]  smp_mo;
  logic signed [ACC_W-1:0]  smp_ro;
  logic                     primed;
  logic                     en;
  logic                     bnd;
  logic                     push;
  logic                     pop;
  logic                     full;
  int                       smp_val;
  logic [ENT_W-1:0]         push_data;
  logic [ENT_W-1:0]         head;

  assign en      = ~i_phi1_NCEN_n;
  assign bnd     = en & dly_sr[DLY-1];
  assign push    = bnd & primed;
  assign pop     = o_VALID & i_READY;
  assign smp_val = sm_to_int(int'(i_SAMPLE), IN_W);
  assign smp_mo  = ACC_W'(smp_val <<< MO_SHIFT);
  assign smp_ro  = ACC_W'(smp_val <<< RO_SHIFT);

  assign push_data = {OUT_W'(sat_int(int'(mo_acc), OUT_W)),
                      OUT_W'(sat_int(int'(ro_acc), OUT_W)),
                      OUT_W'(sat_int(int'(mo_acc) + int'(ro_acc), OUT_W))};

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      dly_sr <= '0;
      mo_acc <= '0;
      ro_acc <= '0;
      primed <= 1'b0;
      o_OVF  <= 1'b0;
    end else begin
      if (en) begin
        dly_sr[0] <= i_CYCLE_00;
        for (int i = 1; i < DLY; i++) dly_sr[i] <= dly_sr[i-1];
        // The boundary cycle closes the frame; its own sample belongs to neither frame.
        if (dly_sr[DLY-1]) begin
          mo_acc <= '0;
          ro_acc <= '0;
          primed <= 1'b1;
        end else if (i_SAMPLE_VALID) begin
          if (i_GROUP) ro_acc <= ro_acc + smp_ro;
          else         mo_acc <= mo_acc + smp_mo;
        end
      end
      if (push & full & ~pop) o_OVF <= 1'b1;
    end
  end

  ikaopll_dac_mixer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .emuclk (i_EMUCLK),
    .rst    (i_RST),
    .push   (push),
    .pop    (pop),
    .din    (push_data),
    .dout   (head),
    .valid  (o_VALID),
    .full   (full)
  );

  assign o_MO_DATA  = head[3*OUT_W-1:2*OUT_W];
  assign o_RO_DATA  = head[2*OUT_W-1:OUT_W];
  assign o_MIX_DATA = head[OUT_W-1:0];

endmodule

// File: tb/tb_ikaopll_dac_mixer.sv
// Bench for ikaopll_dac_mixer: two instances (OUT_W 13 and 10) against a frame-level model.
module tb_ikaopll_dac_mixer;

  localparam int DLY   = 3;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst, ncen, cyc00, sv, grp, rdy;
  logic [8:0] smp;

  logic v13, ovf13, v10, ovf10;
  logic signed [12:0] mo13, ro13, mix13;
  logic signed [9:0]  mo10, ro10, mix10;

  int checks = 0;
  int failures = 0;

  typedef struct { int mo; int ro; } ent_t;
  ent_t q[$];
  int   hist[$];
  int   m_mo, m_ro;
  bit   m_primed, m_ovf;
  bit   rdy_on_bnd = 1'b0;

  always #5 clk = ~clk;

  ikaopll_dac_mixer dut13 (
    .i_EMUCLK(clk), .i_RST(rst), .i_phi1_NCEN_n(ncen), .i_CYCLE_00(cyc00),
    .i_SAMPLE_VALID(sv), .i_GROUP(grp), .i_SAMPLE(smp), .o_VALID(v13), .i_READY(rdy),
    .o_MO_DATA(mo13), .o_RO_DATA(ro13), .o_MIX_DATA(mix13), .o_OVF(ovf13));

  ikaopll_dac_mixer #(.OUT_W(10)) dut10 (
    .i_EMUCLK(clk), .i_RST(rst), .i_phi1_NCEN_n(ncen), .i_CYCLE_00(cyc00),
    .i_SAMPLE_VALID(sv), .i_GROUP(grp), .i_SAMPLE(smp), .o_VALID(v10), .i_READY(rdy),
    .o_MO_DATA(mo10), .o_RO_DATA(ro10), .o_MIX_DATA(mix10), .o_OVF(ovf10));

  function automatic int sat(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic int smval(input logic [8:0] s);
    return s[8] ? -(int'(s[7:0]) + 1) : int'(s[7:0]);
  endfunction

  function automatic int mh(input int sel, input int w);
    if (q.size() == 0) return 0;
    case (sel)
      0:       return sat(q[0].mo, w);
      1:       return sat(q[0].ro, w);
      default: return sat(q[0].mo + q[0].ro, w);
    endcase
  endfunction

  // Frame-level model: marker history, running sums, result queue.
  task automatic model_edge();
    bit b, pop, pushv;
    ent_t e;
    if (rst) begin
      hist.delete();
      repeat (DLY) hist.push_back(0);
      m_mo = 0; m_ro = 0; m_primed = 0; m_ovf = 0;
      q.delete();
      return;
    end
    pop = (q.size() > 0) && rdy;
    pushv = 0;
    e.mo = 0; e.ro = 0;
    if (!ncen) begin
      b = (hist[DLY-1] != 0);
      hist.push_front(int'(cyc00));
      void'(hist.pop_back());
      if (b) begin
        if (m_primed) begin e.mo = m_mo; e.ro = m_ro; pushv = 1; end
        m_primed = 1; m_mo = 0; m_ro = 0;
      end else if (sv) begin
        if (grp) m_ro += smval(smp) * 2;
        else     m_mo += smval(smp);
      end
    end
    if (pop) void'(q.pop_front());
    if (pushv) begin
      if (q.size() < DEPTH) q.push_back(e);
      else m_ovf = 1;
    end
  endtask

  task automatic compare();
    bit ev;
    ev = (q.size() > 0);
    checks++;
    if (v13 !== ev || mo13 !== 13'(mh(0, 13)) || ro13 !== 13'(mh(1, 13)) ||
        mix13 !== 13'(mh(2, 13)) || ovf13 !== m_ovf) begin
      failures++;
      $display("FAIL out13 t=%0t got v=%b mo=%0d ro=%0d mix=%0d ovf=%b want v=%b mo=%0d ro=%0d mix=%0d ovf=%b",
               $time, v13, mo13, ro13, mix13, ovf13, ev, mh(0, 13), mh(1, 13), mh(2, 13), m_ovf);
    end
    checks++;
    if (v10 !== ev || mo10 !== 10'(mh(0, 10)) || ro10 !== 10'(mh(1, 10)) ||
        mix10 !== 10'(mh(2, 10)) || ovf10 !== m_ovf) begin
      failures++;
      $display("FAIL out10 t=%0t got v=%b mo=%0d ro=%0d mix=%0d ovf=%b want v=%b mo=%0d ro=%0d mix=%0d ovf=%b",
               $time, v10, mo10, ro10, mix10, ovf10, ev, mh(0, 10), mh(1, 10), mh(2, 10), m_ovf);
    end
  endtask

  // Hand-computed value pinning both the model and the DUT.
  task automatic lit(input string name, input int got, input int mdl, input int exp);
    checks++;
    if (mdl != exp) begin
      failures++;
      $display("FAIL %s model=%0d want=%0d", name, mdl, exp);
    end
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s dut=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit en, input bit c, input bit s, input bit g,
                      input logic [8:0] d, input bit rd);
    rst = r; ncen = !en; cyc00 = c; sv = s; grp = g; smp = d; rdy = rd;
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic pop1();
    step(0, 0, 0, 0, 0, 9'h0, 1);
  endtask

  // Marker, DLY-1 idle cycles, boundary with a junk sample, then samples for the next frame.
  task automatic frame(input int mo_n, input logic [8:0] mo_raw, input int ro_n,
                       input logic [8:0] ro_raw, input bit rd);
    step(0, 1, 1, 0, 0, 9'h0, rd);
    for (int i = 1; i < DLY; i++) step(0, 1, 0, 0, 0, 9'h0, rd);
    step(0, 1, 0, 1, 0, 9'h0FF, rdy_on_bnd ? 1'b1 : rd);
    for (int i = 0; i < mo_n; i++) step(0, 1, 0, 1, 0, mo_raw, rd);
    step(0, 0, 0, 1, 1, 9'h0AA, rd);
    for (int i = 0; i < ro_n; i++) step(0, 1, 0, 1, 1, ro_raw, rd);
  endtask

  initial begin
    int since_mk;
    bit en, c;
    rst = 1; ncen = 1; cyc00 = 0; sv = 0; grp = 0; smp = 0; rdy = 0;

    step(1, 1, 1, 1, 0, 9'h055, 0);
    lit("reset_valid", int'(v13), int'(q.size() > 0), 0);
    lit("reset_mo", int'(mo13), mh(0, 13), 0);
    lit("reset_ovf", int'(ovf13), int'(m_ovf), 0);

    frame(9, 9'd10, 5, 9'd4, 0);
    frame(0, 9'd0, 0, 9'd0, 0);
    lit("basic_valid", int'(v13), int'(q.size() > 0), 1);
    lit("basic_mo", int'(mo13), mh(0, 13), 90);
    lit("basic_ro", int'(ro13), mh(1, 13), 40);
    lit("basic_mix", int'(mix13), mh(2, 13), 130);
    pop1();

    frame(18, 9'h100, 0, 9'd0, 0);
    pop1();
    frame(0, 9'd0, 0, 9'd0, 0);
    lit("neg_one_mo", int'(mo13), mh(0, 13), -18);
    pop1();

    frame(18, 9'h0FF, 0, 9'd0, 0);
    pop1();
    frame(18, 9'h1FF, 0, 9'd0, 0);
    lit("satp_mo10", int'(mo10), mh(0, 10), 511);
    lit("satp_mix10", int'(mix10), mh(2, 10), 511);
    lit("satp_mo13", int'(mo13), mh(0, 13), 4095);
    pop1();
    frame(0, 9'd0, 0, 9'd0, 0);
    lit("satn_mo10", int'(mo10), mh(0, 10), -512);
    lit("satn_mo13", int'(mo13), mh(0, 13), -4096);
    pop1();

    step(1, 0, 0, 0, 0, 9'h0, 0);
    frame(1, 9'd1, 0, 9'd0, 0);
    frame(1, 9'd2, 0, 9'd0, 0);
    frame(1, 9'd3, 0, 9'd0, 0);
    frame(0, 9'd0, 0, 9'd0, 0);
    lit("ovf_flag", int'(ovf13), int'(m_ovf), 1);
    lit("ovf_head1", int'(mo13), mh(0, 13), 1);
    pop1();
    lit("ovf_head2", int'(mo13), mh(0, 13), 2);
    pop1();
    lit("ovf_empty_valid", int'(v13), int'(q.size() > 0), 0);
    lit("ovf_empty_mo", int'(mo13), mh(0, 13), 0);

    step(1, 0, 0, 0, 0, 9'h0, 0);
    frame(1, 9'd5, 0, 9'd0, 0);
    frame(1, 9'd6, 0, 9'd0, 0);
    frame(1, 9'd7, 0, 9'd0, 0);
    rdy_on_bnd = 1;
    frame(0, 9'd0, 0, 9'd0, 0);
    rdy_on_bnd = 0;
    lit("fullpop_ovf", int'(ovf13), int'(m_ovf), 0);
    lit("fullpop_valid", int'(v13), int'(q.size() > 0), 1);
    lit("fullpop_head", int'(mo13), mh(0, 13), 6);

    frame(2, 9'd3, 0, 9'd0, 1);
    step(1, 1, 0, 1, 0, 9'd9, 0);
    lit("midrst_valid", int'(v13), int'(q.size() > 0), 0);
    lit("midrst_mo", int'(mo13), mh(0, 13), 0);
    frame(1, 9'd4, 0, 9'd0, 0);
    lit("midrst_prime", int'(v13), int'(q.size() > 0), 0);
    frame(0, 9'd0, 0, 9'd0, 0);
    lit("midrst_mo_after", int'(mo13), mh(0, 13), 4);

    step(1, 0, 0, 0, 0, 9'h0, 0);
    since_mk = 0;
    for (int n = 0; n < 4000; n++) begin
      en = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 9) == 0) || (since_mk >= 17);
      if (en) since_mk = c ? 0 : since_mk + 1;
      step($urandom_range(0, 499) == 0, en, c, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 9'($urandom_range(0, 511)), $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
